// File: rtl/bsg_round_robin_n_to_1_burst_pkg.sv
// ---------------------------------------------------------------------------
// bsg_round_robin_n_to_1_burst_pkg
//
// Shared helpers for the round-robin burst concentrator.
//   safe_clog2(x) : ceil(log2(x)), but never less than 1. A one-entry index
//                   still needs a one-bit field.
// ---------------------------------------------------------------------------
package bsg_round_robin_n_to_1_burst_pkg;

   function automatic int safe_clog2(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

endpackage : bsg_round_robin_n_to_1_burst_pkg

// File: rtl/bsg_round_robin_n_to_1_burst_two_fifo.sv
// ---------------------------------------------------------------------------
// bsg_two_fifo
//
// Two-entry FIFO with a registered ready. The enqueue side may accept only
// while there is free space. That free space is known from state alone, so
// ready_o does not depend on yumi_i.
//
// Ports
//   clk_i    in   clock
//   reset_i  in   asynchronous active-high reset; empties the FIFO
//   ready_o  out  room for an entry (count < 2) and not in reset
//   data_i   in   width_p  entry to enqueue
//   v_i      in   enqueue request; an entry is written when v_i & ready_o
//   v_o      out  head entry is valid
//   data_o   out  width_p  head entry (raw storage, not gated)
//   yumi_i   in   consumer takes the head; ignored while empty
// ---------------------------------------------------------------------------
module bsg_two_fifo #(
   parameter int width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   input  logic               v_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   logic [width_p-1:0] mem_r [2];
   logic               head_r;
   logic               tail_r;
   logic [1:0]         count_r;
   logic               enq;
   logic               deq;

   assign ready_o = (count_r != 2'd2) & ~reset_i;
   assign v_o     = (count_r != 2'd0);
   assign enq     = v_i & ready_o;
   // A dequeue while empty is dropped, so an illegal yumi cannot underflow.
   assign deq     = yumi_i & v_o;
   assign data_o  = mem_r[head_r];

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         head_r  <= 1'b0;
         tail_r  <= 1'b0;
         count_r <= 2'd0;
      end else begin
         // NOTE: state registers use non-blocking assignments. Every flop then
         // samples pre-edge values, whatever the order of the statements.
         if (enq) tail_r <= ~tail_r;
         if (deq) head_r <= ~head_r;
         count_r <= count_r + {1'b0, enq} - {1'b0, deq};
      end
   end

   // NOTE: the storage array is deliberately not reset. Reset clears count_r,
   // so a stale entry is never presented. Leaving the array unreset keeps it a
   // plain register file.
   always_ff @(posedge clk_i) begin
      if (enq) mem_r[tail_r] <= data_i;
   end

endmodule : bsg_two_fifo

// File: rtl/bsg_round_robin_n_to_1_burst.sv
// ---------------------------------------------------------------------------
// bsg_round_robin_n_to_1_burst
//
// N-to-1 round-robin concentrator. It has a registered two-entry output
// buffer and burst affinity. The input that wins may keep the grant for up to
// burst_p back-to-back transfers, provided it keeps requesting. After that,
// priority rotates to the next channel. The grant depends only on v_i and
// registered state, so the consumer's yumi_i never reaches yumi_o.
//
// Parameters
//   num_in_p      number of input channels (>= 2)
//   width_p       payload width per channel
//   burst_p       max consecutive grants to one channel (>= 1; 1 = pure RR)
//   tag_width_lp  derived source-index width (not overridable)
//
// Ports
//   clk_i    in   clock
//   reset_i  in   asynchronous active-high reset
//   data_i   in   num_in_p*width_p; channel k at [k*width_p +: width_p]
//   v_i      in   num_in_p per-channel valid
//   yumi_o   out  num_in_p one-hot-or-zero; channel k taken this cycle
//   v_o      out  buffer head valid
//   data_o   out  width_p head payload, 0 when v_o = 0
//   tag_o    out  tag_width_lp source channel of the head, 0 when v_o = 0
//   yumi_i   in   consumer takes the head (legal only when v_o = 1)
// ---------------------------------------------------------------------------
module bsg_round_robin_n_to_1_burst
   import bsg_round_robin_n_to_1_burst_pkg::*;
#(
   parameter  int num_in_p     = 4,
   parameter  int width_p      = 16,
   parameter  int burst_p      = 1,
   localparam int tag_width_lp = safe_clog2(num_in_p)
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic [num_in_p*width_p-1:0] data_i,
   input  logic [num_in_p-1:0]         v_i,
   output logic [num_in_p-1:0]         yumi_o,
   output logic                        v_o,
   output logic [width_p-1:0]          data_o,
   output logic [tag_width_lp-1:0]     tag_o,
   input  logic                        yumi_i
);

   localparam int cnt_width_lp = safe_clog2(burst_p + 1);
   localparam int fifo_width_lp = tag_width_lp + width_p;

   localparam logic [tag_width_lp-1:0] last_init_lp = tag_width_lp'(num_in_p - 1);
   localparam logic [tag_width_lp:0]   rot_one_lp   = (tag_width_lp + 1)'(1);
   localparam logic [tag_width_lp:0]   num_in_lp    = (tag_width_lp + 1)'(num_in_p);
   localparam logic [cnt_width_lp-1:0] cnt_one_lp   = cnt_width_lp'(1);
   localparam logic [cnt_width_lp-1:0] burst_max_lp = cnt_width_lp'(burst_p);

   // Arbitration state
   logic [tag_width_lp-1:0] last_r;
   logic [cnt_width_lp-1:0] burst_cnt_r;

   // Arbiter datapath
   logic [2*num_in_p-1:0]   v_dbl;
   logic [num_in_p-1:0]     v_rot;
   logic [tag_width_lp:0]   rot_amt;
   logic [tag_width_lp:0]   unrot_sum;
   logic [tag_width_lp-1:0] rot_idx;
   logic                    rot_found;
   logic                    sticky;
   logic [tag_width_lp-1:0] grant_tag;
   logic                    grant_v;
   logic                    ready;
   logic                    accept;
   logic [width_p-1:0]      sel_data;

   // Buffer side
   logic                     fifo_v;
   logic [fifo_width_lp-1:0] fifo_data;

   assign v_dbl = {v_i, v_i};

   always_comb begin
      // NOTE: every variable written here is given a default first. No path
      // then leaves one unassigned, so no latch is inferred.
      rot_found = 1'b0;
      rot_idx   = '0;

      // Rotate so that bit 0 is channel last_r+1. The doubled vector makes
      // the wrap-around a plain part-select.
      rot_amt = {1'b0, last_r} + rot_one_lp;
      v_rot   = v_dbl[rot_amt +: num_in_p];

      // Priority-encode the lowest requesting position in rotated order.
      for (int j = 0; j < num_in_p; j++) begin
         if (!rot_found && v_rot[j]) begin
            rot_found = 1'b1;
            rot_idx   = tag_width_lp'(j);
         end
      end

      // Un-rotate back to a channel index, modulo num_in_p.
      unrot_sum = {1'b0, rot_idx} + rot_amt;
      if (unrot_sum >= num_in_lp) unrot_sum = unrot_sum - num_in_lp;

      // The burst holder keeps the grant until its count reaches burst_p.
      // burst_cnt_r = 0 means no burst is in progress.
      sticky = (burst_cnt_r != '0) && (burst_cnt_r < burst_max_lp) && v_i[last_r];

      grant_tag = sticky ? last_r : unrot_sum[tag_width_lp-1:0];
      grant_v   = sticky | rot_found;
   end

   always_comb begin
      yumi_o   = '0;
      sel_data = '0;
      for (int k = 0; k < num_in_p; k++) begin
         yumi_o[k] = grant_v & ready & (grant_tag == tag_width_lp'(k));
         if (grant_tag == tag_width_lp'(k)) sel_data = data_i[k*width_p +: width_p];
      end
   end

   assign accept = grant_v & ready;

   // If no accept happens, the burst state holds, so a stall keeps the burst.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         last_r      <= last_init_lp;
         burst_cnt_r <= '0;
      end else if (accept) begin
         last_r <= grant_tag;
         if (grant_tag == last_r)
            burst_cnt_r <= (burst_cnt_r == burst_max_lp) ? burst_max_lp
                                                         : burst_cnt_r + cnt_one_lp;
         else
            burst_cnt_r <= cnt_one_lp;
      end
   end

   // The FIFO's ready_o is the accept gate. Its enqueue condition
   // (grant_v & ready_o) is the same as accept.
   bsg_two_fifo #(
      .width_p (fifo_width_lp)
   ) fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .ready_o (ready),
      .data_i  ({grant_tag, sel_data}),
      .v_i     (grant_v),
      .v_o     (fifo_v),
      .data_o  (fifo_data),
      .yumi_i  (yumi_i)
   );

   assign v_o    = fifo_v;
   assign tag_o  = fifo_v ? fifo_data[width_p +: tag_width_lp] : '0;
   assign data_o = fifo_v ? fifo_data[width_p-1:0] : '0;

   // A consumer yumi with nothing presented is a protocol error. The FIFO
   // drops it, but it is still flagged here.
   yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
                                      (yumi_i |-> v_o));

endmodule : bsg_round_robin_n_to_1_burst

// File: tb/tb_bsg_round_robin_n_to_1_burst.sv
// ---------------------------------------------------------------------------
// tb_bsg_round_robin_n_to_1_burst
//
// dut  : num_in_p=4, width_p=16, burst_p=2 (table-driven + scoreboard)
// dut1 : num_in_p=4, width_p=16, burst_p=1 (pure round-robin sequence)
// Inputs change 1 time unit after the rising edge; outputs are sampled
// mid-cycle or shortly after input changes.
// ---------------------------------------------------------------------------
module tb_bsg_round_robin_n_to_1_burst;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;

   logic [63:0] data_i = '0;
   logic [3:0]  v_i = '0;
   logic [3:0]  yumi_o;
   logic        v_o;
   logic [15:0] data_o;
   logic [1:0]  tag_o;
   logic        yumi_i = 1'b0;

   logic [63:0] data1 = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
   logic [3:0]  v1 = '0;
   logic [3:0]  yumi_o1;
   logic        v_o1;
   logic [15:0] data_o1;
   logic [1:0]  tag_o1;
   logic        yumi1 = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [11:0] seq [4] = '{12'h000, 12'h100, 12'h200, 12'h300};
   logic [17:0] sb_q [$];

   typedef struct {
      logic       rst;
      logic [3:0] v;
      logic       yumi;
      logic [3:0] exp_yumi_o;
      logic       exp_v;
      logic [1:0] exp_tag;
   } vec_t;

   vec_t vecs [$];

   always #5 clk = ~clk;

   bsg_round_robin_n_to_1_burst #(
      .num_in_p (4), .width_p (16), .burst_p (2)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .data_i  (data_i),
      .v_i     (v_i),
      .yumi_o  (yumi_o),
      .v_o     (v_o),
      .data_o  (data_o),
      .tag_o   (tag_o),
      .yumi_i  (yumi_i)
   );

   bsg_round_robin_n_to_1_burst #(
      .num_in_p (4), .width_p (16), .burst_p (1)
   ) dut1 (
      .clk_i   (clk),
      .reset_i (reset_i),
      .data_i  (data1),
      .v_i     (v1),
      .yumi_o  (yumi_o1),
      .v_o     (v_o1),
      .data_o  (data_o1),
      .tag_o   (tag_o1),
      .yumi_i  (yumi1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Each producer's payload is {channel, running sequence number}. A lost or
   // duplicated transfer therefore shows up as a data error.
   task automatic drive_data();
      for (int k = 0; k < 4; k++) data_i[k*16 +: 16] = {4'(k), seq[k]};
   endtask

   task automatic add(input logic rst, input logic [3:0] v, input logic yumi,
                      input logic [3:0] ey, input logic ev, input logic [1:0] et);
      vec_t r;
      r.rst = rst; r.v = v; r.yumi = yumi;
      r.exp_yumi_o = ey; r.exp_v = ev; r.exp_tag = et;
      vecs.push_back(r);
   endtask

   // Entered just after a rising edge and left just after a rising edge,
   // with reset released.
   task automatic do_reset();
      reset_i = 1'b1;
      v_i = 4'hF; yumi_i = 1'b0; v1 = 4'hF; yumi1 = 1'b0;
      drive_data();
      #1;
      check("rst yumi_o", 32'(yumi_o), 32'h0);
      check("rst v_o", 32'(v_o), 32'h0);
      check("rst data_o", 32'(data_o), 32'h0);
      check("rst tag_o", 32'(tag_o), 32'h0);
      check("rst dut1 yumi_o", 32'(yumi_o1), 32'h0);
      @(posedge clk); #1;
      check("rst hold yumi_o", 32'(yumi_o), 32'h0);
      check("rst hold v_o", 32'(v_o), 32'h0);
      v1 = 4'h0;
      reset_i = 1'b0;
   endtask

   // Scoreboard. Each accept seen on yumo_o pushes the {tag, payload} that
   // should appear later. Whenever the head is valid it is compared against
   // the oldest outstanding entry, which is popped on a consumer yumi.
   always @(negedge clk) begin
      if (reset_i) begin
         sb_q.delete();
      end else begin
         if (v_o) begin
            if (sb_q.size() == 0) begin
               check("sb unexpected head", 32'({tag_o, data_o}), 32'h3FFFF);
            end else begin
               check("sb head", 32'({tag_o, data_o}), 32'(sb_q[0]));
               if (yumi_i) void'(sb_q.pop_front());
            end
         end
         for (int k = 0; k < 4; k++) begin
            if (yumi_o[k]) begin
               sb_q.push_back({2'(k), data_i[k*16 +: 16]});
               seq[k] = seq[k] + 12'd1;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // rst  v     yumi  yumi_o v_o tag
      // Reset priority, burst 2: tags 0,0,1,1,2,2,3,3,0
      add(1, 4'hF, 0, 4'h1, 0, 0);
      add(0, 4'hF, 1, 4'h1, 1, 0);
      add(0, 4'hF, 1, 4'h2, 1, 0);
      add(0, 4'hF, 1, 4'h2, 1, 1);
      add(0, 4'hF, 1, 4'h4, 1, 1);
      add(0, 4'hF, 1, 4'h4, 1, 2);
      add(0, 4'hF, 1, 4'h8, 1, 2);
      add(0, 4'hF, 1, 4'h8, 1, 3);
      add(0, 4'hF, 1, 4'h1, 1, 3);
      add(0, 4'hF, 1, 4'h1, 1, 0);
      // Backpressure: two accepts, then stall at full, then resume
      add(1, 4'h1, 0, 4'h1, 0, 0);
      add(0, 4'h1, 0, 4'h1, 1, 0);
      add(0, 4'h1, 0, 4'h0, 1, 0);
      add(0, 4'h1, 0, 4'h0, 1, 0);
      add(0, 4'h1, 1, 4'h0, 1, 0);
      add(0, 4'h1, 1, 4'h1, 1, 0);
      add(0, 4'h1, 1, 4'h1, 1, 0);
      add(0, 4'h0, 1, 4'h0, 1, 0);
      add(0, 4'h0, 0, 4'h0, 0, 0);
      // Burst break: ch2 once, drops, ch3 gets a fresh burst of two
      add(1, 4'h4, 0, 4'h4, 0, 0);
      add(0, 4'h8, 1, 4'h8, 1, 2);
      add(0, 4'hC, 1, 4'h8, 1, 3);
      add(0, 4'hC, 1, 4'h4, 1, 3);
      add(0, 4'h0, 1, 4'h0, 1, 2);
      add(0, 4'h0, 0, 4'h0, 0, 0);
      // Full buffer ignores same-cycle consumer yumi, then steady state
      add(1, 4'hF, 0, 4'h1, 0, 0);
      add(0, 4'hF, 0, 4'h1, 1, 0);
      add(0, 4'hF, 0, 4'h0, 1, 0);
      add(0, 4'hF, 1, 4'h0, 1, 0);
      add(0, 4'hF, 1, 4'h2, 1, 0);
      add(0, 4'hF, 1, 4'h2, 1, 1);
      add(0, 4'hF, 1, 4'h4, 1, 1);
      add(0, 4'h0, 1, 4'h0, 1, 2);
      add(0, 4'h0, 0, 4'h0, 0, 0);

      @(posedge clk); #1;
      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         v_i = vecs[i].v;
         yumi_i = vecs[i].yumi;
         drive_data();
         @(negedge clk);
         check($sformatf("vec%0d yumi_o", i), 32'(yumi_o), 32'(vecs[i].exp_yumi_o));
         check($sformatf("vec%0d v_o", i), 32'(v_o), 32'(vecs[i].exp_v));
         check($sformatf("vec%0d tag_o", i), 32'(tag_o), 32'(vecs[i].exp_tag));
         if (!vecs[i].exp_v) check($sformatf("vec%0d data_o", i), 32'(data_o), 32'h0);
         @(posedge clk); #1;
      end

      // Pure round-robin (burst_p=1) with v=1010: tags 1,3,1,3
      begin
         logic [3:0] exp_y [5];
         logic [1:0] exp_t [5];
         exp_y = '{4'h2, 4'h8, 4'h2, 4'h8, 4'h2};
         exp_t = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd3};
         do_reset();
         v_i = 4'h0;
         for (int i = 0; i < 5; i++) begin
            v1 = 4'hA;
            yumi1 = (i > 0);
            @(negedge clk);
            check($sformatf("rr%0d yumi_o", i), 32'(yumi_o1), 32'(exp_y[i]));
            check($sformatf("rr%0d v_o", i), 32'(v_o1), (i > 0) ? 32'h1 : 32'h0);
            if (i > 0) begin
               check($sformatf("rr%0d tag_o", i), 32'(tag_o1), 32'(exp_t[i]));
               check($sformatf("rr%0d data_o", i), 32'(data_o1), 32'(16'hA000 + 16'(exp_t[i])));
            end
            @(posedge clk); #1;
         end
         v1 = 4'h0;
         yumi1 = 1'b0;
         @(posedge clk); #1;
      end

      // Async reset mid-stream with the buffer full
      do_reset();
      v_i = 4'h1; yumi_i = 1'b0; drive_data();
      @(posedge clk); #1;
      check("mid count1 v_o", 32'(v_o), 32'h1);
      @(posedge clk); #1;
      check("mid full v_o", 32'(v_o), 32'h1);
      check("mid full yumi_o", 32'(yumi_o), 32'h0);
      reset_i = 1'b1;
      #1;
      check("mid rst v_o", 32'(v_o), 32'h0);
      check("mid rst yumi_o", 32'(yumi_o), 32'h0);
      check("mid rst data_o", 32'(data_o), 32'h0);
      check("mid rst tag_o", 32'(tag_o), 32'h0);
      @(posedge clk); #1;
      reset_i = 1'b0; v_i = 4'hF; drive_data();
      #1;
      check("post rst yumi_o", 32'(yumi_o), 32'h1);
      check("post rst v_o", 32'(v_o), 32'h0);
      @(posedge clk); #1;
      v_i = 4'h0; yumi_i = 1'b1;
      #1;
      check("post rst head v_o", 32'(v_o), 32'h1);
      check("post rst head tag", 32'(tag_o), 32'h0);
      @(posedge clk); #1;
      yumi_i = 1'b0;
      #1;
      check("post rst drained v_o", 32'(v_o), 32'h0);

      // Reset asserted while a producer's yumi_o is high: not accepted
      do_reset();
      v_i = 4'h1; yumi_i = 1'b0; drive_data();
      #1;
      check("yumi rst pre yumi_o", 32'(yumi_o), 32'h1);
      reset_i = 1'b1;
      #1;
      check("yumi rst yumi_o", 32'(yumi_o), 32'h0);
      @(posedge clk); #1;
      reset_i = 1'b0; v_i = 4'h0;
      #1;
      check("yumi rst not accepted", 32'(v_o), 32'h0);
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_bsg_round_robin_n_to_1_burst
